// File: rtl/pipelined_decode.sv
// RV32I decode stage: register file read, immediate and control decode
// into a single valid/ready output register with a load-use interlock.
module pipelined_decode #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instruction,
  output logic            o_valid,
  input  logic            i_ready,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_opsel,
  output logic            o_sub,
  output logic            o_arith,
  output logic            o_unsigned,
  output logic            o_alu_src,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_mem_to_reg,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal,
  input  logic            i_reg_write_en,
  input  logic [4:0]      i_reg_write_addr,
  input  logic [XLEN-1:0] i_reg_write_data
);

  localparam int AW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic in_range(input logic [4:0] a);
    return {1'b0, a} < 6'(NUM_REGS);
  endfunction

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;

  logic [6:0] opc;
  logic [4:0] rs1_a, rs2_a, rd_a;
  logic [2:0] f3;
  logic       shift_op;

  assign opc      = i_instruction[6:0];
  assign rd_a     = i_instruction[11:7];
  assign f3       = i_instruction[14:12];
  assign rs1_a    = i_instruction[19:15];
  assign rs2_a    = i_instruction[24:20];
  assign shift_op = (f3 == 3'b001) || (f3 == 3'b101);

  logic [XLEN-1:0] rs1_data_d, rs2_data_d, imm_d;
  logic [31:0]     imm32;
  logic [2:0]      opsel_d;
  logic sub_d, arith_d, uns_d, alu_src_d, rw_d;
  logic mr_d, mw_d, m2r_d, br_d, jmp_d, ill_d;
  logic bad_op, use_rs1, use_rs2;

  always_comb begin
    imm32     = '0;
    opsel_d   = '0;
    sub_d     = 1'b0;
    arith_d   = 1'b0;
    uns_d     = 1'b0;
    alu_src_d = 1'b0;
    rw_d      = 1'b0;
    mr_d      = 1'b0;
    mw_d      = 1'b0;
    m2r_d     = 1'b0;
    br_d      = 1'b0;
    jmp_d     = 1'b0;
    bad_op    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    unique case (1'b1)
      (opc == OPC_LUI), (opc == OPC_AUIPC): begin
        imm32     = {i_instruction[31:12], 12'b0};
        alu_src_d = 1'b1;
        rw_d      = 1'b1;
      end
      (opc == OPC_JAL): begin
        imm32     = {{12{i_instruction[31]}}, i_instruction[19:12],
                     i_instruction[20], i_instruction[30:21], 1'b0};
        alu_src_d = 1'b1;
        rw_d      = 1'b1;
        jmp_d     = 1'b1;
      end
      (opc == OPC_JALR): begin
        imm32     = {{20{i_instruction[31]}}, i_instruction[31:20]};
        alu_src_d = 1'b1;
        rw_d      = 1'b1;
        jmp_d     = 1'b1;
        use_rs1   = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        imm32   = {{20{i_instruction[31]}}, i_instruction[7],
                   i_instruction[30:25], i_instruction[11:8], 1'b0};
        opsel_d = f3;
        uns_d   = (f3 == 3'b110) || (f3 == 3'b111);
        br_d    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      (opc == OPC_LOAD): begin
        imm32     = {{20{i_instruction[31]}}, i_instruction[31:20]};
        opsel_d   = f3;
        uns_d     = (f3 == 3'b100) || (f3 == 3'b101);
        alu_src_d = 1'b1;
        rw_d      = 1'b1;
        mr_d      = 1'b1;
        m2r_d     = 1'b1;
        use_rs1   = 1'b1;
      end
      (opc == OPC_STORE): begin
        imm32     = {{20{i_instruction[31]}}, i_instruction[31:25],
                     i_instruction[11:7]};
        opsel_d   = f3;
        alu_src_d = 1'b1;
        mw_d      = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      (opc == OPC_OPIMM): begin
        imm32     = {{20{i_instruction[31]}}, i_instruction[31:20]};
        opsel_d   = f3;
        uns_d     = (f3 == 3'b011);
        arith_d   = shift_op & i_instruction[30];
        alu_src_d = 1'b1;
        rw_d      = 1'b1;
        use_rs1   = 1'b1;
      end
      (opc == OPC_OP): begin
        opsel_d = f3;
        uns_d   = (f3 == 3'b011);
        sub_d   = i_instruction[30];
        arith_d = shift_op & i_instruction[30];
        rw_d    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase
    ill_d = bad_op
          | (use_rs1 & ~in_range(rs1_a))
          | (use_rs2 & ~in_range(rs2_a))
          | (rw_d & ~in_range(rd_a));
    // An illegal word must never leave side effects downstream
    if (ill_d) begin
      rw_d  = 1'b0;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      m2r_d = 1'b0;
      br_d  = 1'b0;
      jmp_d = 1'b0;
    end
  end

  assign imm_d = XLEN'($signed(imm32));

  always_comb begin
    rs1_data_d = '0;
    if (rs1_a != '0 && in_range(rs1_a)) begin
      rs1_data_d = regs_q[rs1_a[AW-1:0]];
      if (BYPASS && i_reg_write_en && i_reg_write_addr == rs1_a)
        rs1_data_d = i_reg_write_data;
    end
  end

  always_comb begin
    rs2_data_d = '0;
    if (rs2_a != '0 && in_range(rs2_a)) begin
      rs2_data_d = regs_q[rs2_a[AW-1:0]];
      if (BYPASS && i_reg_write_en && i_reg_write_addr == rs2_a)
        rs2_data_d = i_reg_write_data;
    end
  end

  logic valid_q, stall, accept;

  assign stall = valid_q & o_mem_read & (o_rd != '0) & i_valid
               & ((use_rs1 & (rs1_a == o_rd))
               |  (use_rs2 & (rs2_a == o_rd)));

  assign o_ready = (~valid_q | i_ready) & ~stall;
  assign accept  = i_valid & o_ready;
  assign o_valid = valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs_q <= '0;
    end else if (i_reg_write_en && i_reg_write_addr != '0
                 && in_range(i_reg_write_addr)) begin
      regs_q[i_reg_write_addr[AW-1:0]] <= i_reg_write_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      o_rs1_data   <= '0;
      o_rs2_data   <= '0;
      o_imm        <= '0;
      o_rd         <= '0;
      o_opsel      <= '0;
      o_sub        <= 1'b0;
      o_arith      <= 1'b0;
      o_unsigned   <= 1'b0;
      o_alu_src    <= 1'b0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_branch     <= 1'b0;
      o_jump       <= 1'b0;
      o_illegal    <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q      <= 1'b1;
      o_rs1_data   <= rs1_data_d;
      o_rs2_data   <= rs2_data_d;
      o_imm        <= imm_d;
      o_rd         <= rd_a;
      o_opsel      <= opsel_d;
      o_sub        <= sub_d;
      o_arith      <= arith_d;
      o_unsigned   <= uns_d;
      o_alu_src    <= alu_src_d;
      o_reg_write  <= rw_d;
      o_mem_read   <= mr_d;
      o_mem_write  <= mw_d;
      o_mem_to_reg <= m2r_d;
      o_branch     <= br_d;
      o_jump       <= jmp_d;
      o_illegal    <= ill_d;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule
